// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter / stall sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        WAIT_IN  = 2'b01,
        WAIT_OUT = 2'b10,
        HALTED   = 2'b11
    } seq_state_t;

    localparam int unsigned ADDR_W_DEFAULT = 10;
    localparam int unsigned SWITCH_W       = 16;
    localparam int unsigned IN_ZEXT_W      = 32 - SWITCH_W;

    // Board switches widened to a register-file word.
    function automatic logic [31:0] zext_switches(input logic [SWITCH_W-1:0] sw);
        return {{IN_ZEXT_W{1'b0}}, sw};
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Synchronizes the raw confirm button and emits a one-cycle pulse on each
// rising edge of the synchronized level.
module btn_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    // Fewer than two stages would leave metastability unresolved.
    localparam int unsigned STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] sync;
    logic              prev;

    // Synchronizer chain, previous-level flop and registered edge pulse.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync  <= '0;
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            sync  <= {sync[STAGES-2:0], btn};
            prev  <= sync[STAGES-1];
            pulse <= sync[STAGES-1] & ~prev;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC selection, stall/halt sequencing and the IN/OUT operator handshake
// for the single-cycle core.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pc_signal,
    input  logic              jump,
    input  logic              branch,
    input  logic              branch_cond,
    input  logic [ADDR_W-1:0] target,
    input  logic              halt,
    input  logic              is_in,
    input  logic              is_out,
    input  logic              write,
    input  logic [31:0]       reg_data,
    input  logic [15:0]       switches,
    input  logic              confirm_btn,
    output logic [ADDR_W-1:0] pc,
    output logic              reg_write,
    output logic [31:0]       in_data,
    output logic [31:0]       out_data,
    output logic              stall,
    output logic              halted
);

    seq_state_t        state;
    logic              pulse;
    logic              entry_cycle;
    logic              confirm;
    logic [ADDR_W-1:0] pc_inc;

    btn_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_btn (
        .clock(clock),
        .reset(reset),
        .btn  (confirm_btn),
        .pulse(pulse)
    );

    // A pulse in the first WAIT cycle comes from a button that was already
    // high when the WAIT state was entered, so it is not a confirm.
    always_comb begin
        confirm = pulse & ~entry_cycle;
        pc_inc  = pc + ADDR_W'(1);
    end

    // Register-file write gating; forced low while reset is asserted so an
    // abandoned IN never writes.
    always_comb begin
        reg_write = 1'b0;
        if (reset) begin
            case (state)
                RUN:     reg_write = write & ~is_in;
                WAIT_IN: reg_write = confirm;
                default: reg_write = 1'b0;
            endcase
        end
    end

    // Sequencer FSM with registered pc, data latches and stall decodes.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= RUN;
            pc          <= '0;
            in_data     <= '0;
            out_data    <= '0;
            stall       <= 1'b0;
            halted      <= 1'b0;
            entry_cycle <= 1'b0;
        end else begin
            entry_cycle <= 1'b0;
            case (state)
                RUN: begin
                    if (is_in) begin
                        state       <= WAIT_IN;
                        stall       <= 1'b1;
                        entry_cycle <= 1'b1;
                    end else if (is_out) begin
                        state       <= WAIT_OUT;
                        stall       <= 1'b1;
                        entry_cycle <= 1'b1;
                        out_data    <= reg_data;
                    end else if (halt) begin
                        state  <= HALTED;
                        stall  <= 1'b1;
                        halted <= 1'b1;
                    end else if (!pc_signal) begin
                        pc <= pc_inc;
                    end else if (jump) begin
                        pc <= target;
                    end else if (branch && branch_cond) begin
                        pc <= target;
                    end else begin
                        pc <= pc_inc;
                    end
                end
                WAIT_IN: begin
                    if (confirm) begin
                        in_data <= zext_switches(switches);
                        pc      <= pc_inc;
                        state   <= RUN;
                        stall   <= 1'b0;
                    end
                end
                WAIT_OUT: begin
                    if (confirm) begin
                        pc    <= pc_inc;
                        state <= RUN;
                        stall <= 1'b0;
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state  <= RUN;
                    stall  <= 1'b0;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: reset state, a table of RUN-mode PC vectors,
// directed IN/OUT/HALT/reset sequences and a randomized run against a
// spec-level reference model.
`timescale 1ns/1ps
module tb_pc_sequencer;

    localparam int AW = 10;
    localparam int S  = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          pc_signal, jump, branch, branch_cond, halt, is_in, is_out, write;
    logic [AW-1:0] target;
    logic [31:0]   reg_data;
    logic [15:0]   switches;
    logic          confirm_btn = 1'b0;
    logic [AW-1:0] pc;
    logic          reg_write, stall, halted;
    logic [31:0]   in_data, out_data;

    always #5 clock = ~clock;

    pc_sequencer #(.ADDR_W(AW), .SYNC_STAGES(S)) dut (
        .clock(clock), .reset(reset), .pc_signal(pc_signal), .jump(jump),
        .branch(branch), .branch_cond(branch_cond), .target(target),
        .halt(halt), .is_in(is_in), .is_out(is_out), .write(write),
        .reg_data(reg_data), .switches(switches), .confirm_btn(confirm_btn),
        .pc(pc), .reg_write(reg_write), .in_data(in_data), .out_data(out_data),
        .stall(stall), .halted(halted)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle();
        pc_signal = 1'b0; jump = 1'b0; branch = 1'b0; branch_cond = 1'b0;
        halt = 1'b0; is_in = 1'b0; is_out = 1'b0; write = 1'b0;
        target = '0;
    endtask

    typedef struct {
        logic          ps, jmp, br, cond, wr;
        logic [AW-1:0] tgt;
        logic [AW-1:0] exp_pc;
    } vec_t;

    function automatic vec_t mk(input logic ps, input logic jmp, input logic br,
                                input logic cond, input logic wr,
                                input logic [AW-1:0] tgt, input logic [AW-1:0] exp_pc);
        vec_t v;
        v.ps = ps; v.jmp = jmp; v.br = br; v.cond = cond; v.wr = wr;
        v.tgt = tgt; v.exp_pc = exp_pc;
        return v;
    endfunction

    vec_t vecs[12];

    // Reference model state (spec-level modes)
    localparam int M_RUN = 0, M_IN = 1, M_OUT = 2, M_HALT = 3;
    int            m_mode;
    int            m_cyc;
    int            m_entry;
    logic [AW-1:0] m_pc;
    logic [31:0]   m_in, m_out;
    logic          hist[$];

    task automatic model_reset();
        m_mode = M_RUN; m_cyc = 0; m_entry = -1;
        m_pc = '0; m_in = '0; m_out = '0;
        hist.delete();
        for (int i = 0; i < S + 2; i++) hist.push_back(1'b0);
    endtask

    initial begin
        logic          pulse_now, commit_now, exp_rw;
        int            l;

        vecs[0]  = mk(0, 0, 0, 0, 1, 10'h000, 10'h001);
        vecs[1]  = mk(0, 0, 0, 0, 0, 10'h000, 10'h002);
        vecs[2]  = mk(1, 1, 0, 0, 1, 10'h05A, 10'h05A);
        vecs[3]  = mk(1, 0, 1, 0, 0, 10'h3FF, 10'h05B);
        vecs[4]  = mk(1, 0, 1, 1, 1, 10'h010, 10'h010);
        vecs[5]  = mk(1, 1, 1, 0, 0, 10'h200, 10'h200);
        vecs[6]  = mk(0, 1, 0, 0, 1, 10'h300, 10'h201);
        vecs[7]  = mk(1, 1, 0, 0, 0, 10'h3FF, 10'h3FF);
        vecs[8]  = mk(0, 0, 0, 0, 1, 10'h000, 10'h000);
        vecs[9]  = mk(1, 0, 1, 1, 0, 10'h3FE, 10'h3FE);
        vecs[10] = mk(1, 0, 0, 0, 1, 10'h123, 10'h3FF);
        vecs[11] = mk(0, 0, 0, 1, 0, 10'h000, 10'h000);

        idle();
        reg_data = '0; switches = '0;

        // Reset state, with write high to show reg_write is held off
        write = 1'b1;
        @(negedge clock);
        tick();
        check("reset_reg_write", 32'(reg_write), 32'd0);
        tick();
        check("reset_pc", 32'(pc), 32'd0);
        check("reset_in_data", in_data, 32'd0);
        check("reset_out_data", out_data, 32'd0);
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_halted", 32'(halted), 32'd0);
        write = 1'b0;
        reset = 1'b1;

        // Sequential fetch 0..10
        check("seq_pc0", 32'(pc), 32'd0);
        for (int i = 1; i <= 10; i++) begin
            tick();
            check("seq_pc", 32'(pc), 32'(i));
        end

        // Table of RUN-mode next-PC vectors, starting from pc 0
        reset = 1'b0; tick(); reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            pc_signal = vecs[i].ps; jump = vecs[i].jmp; branch = vecs[i].br;
            branch_cond = vecs[i].cond; write = vecs[i].wr; target = vecs[i].tgt;
            #1;
            check("vec_reg_write", 32'(reg_write), 32'(vecs[i].wr));
            tick();
            check("vec_pc", 32'(pc), 32'(vecs[i].exp_pc));
            check("vec_stall", 32'(stall), 32'd0);
        end

        // IN handshake at pc 7
        idle(); pc_signal = 1'b1; jump = 1'b1; target = 10'd7;
        tick();
        check("in_setup_pc", 32'(pc), 32'd7);
        idle(); pc_signal = 1'b1; halt = 1'b1; is_in = 1'b1; write = 1'b1;
        switches = 16'h00A5;
        #1;
        check("in_run_reg_write", 32'(reg_write), 32'd0);
        tick();
        check("in_stall", 32'(stall), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("in_hold_pc", 32'(pc), 32'd7);
            check("in_hold_reg_write", 32'(reg_write), 32'd0);
            tick();
        end
        confirm_btn = 1'b1;
        tick();
        check("in_pre_rw1", 32'(reg_write), 32'd0);
        tick();
        check("in_pre_rw2", 32'(reg_write), 32'd0);
        tick();
        check("in_commit_reg_write", 32'(reg_write), 32'd1);
        check("in_commit_pc_hold", 32'(pc), 32'd7);
        idle();
        tick();
        check("in_done_pc", 32'(pc), 32'd8);
        check("in_done_stall", 32'(stall), 32'd0);
        check("in_data", in_data, 32'h0000_00A5);
        check("in_done_reg_write", 32'(reg_write), 32'd0);
        confirm_btn = 1'b0;
        tick(); tick(); tick();
        check("in_run_pc", 32'(pc), 32'd11);

        // OUT with the button already held
        confirm_btn = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("out_pre_pc", 32'(pc), 32'd15);
        pc_signal = 1'b1; halt = 1'b1; is_out = 1'b1; reg_data = 32'hDEADBEEF;
        tick();
        check("out_latch", out_data, 32'hDEADBEEF);
        check("out_stall", 32'(stall), 32'd1);
        reg_data = 32'h1234_5678;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("out_held_btn_pc", 32'(pc), 32'd15);
            check("out_held_btn_stall", 32'(stall), 32'd1);
        end
        confirm_btn = 1'b0;
        tick(); tick(); tick();
        check("out_release_pc", 32'(pc), 32'd15);
        confirm_btn = 1'b1;
        tick(); tick(); tick();
        check("out_commit_reg_write", 32'(reg_write), 32'd0);
        idle();
        tick();
        check("out_done_pc", 32'(pc), 32'd16);
        check("out_done_stall", 32'(stall), 32'd0);
        check("out_data_hold", out_data, 32'hDEADBEEF);
        confirm_btn = 1'b0;
        tick(); tick(); tick();

        // Reset on the IN commit edge abandons the transfer
        pc_signal = 1'b1; halt = 1'b1; is_in = 1'b1; switches = 16'h1234;
        tick();
        check("rin_stall", 32'(stall), 32'd1);
        check("rin_in_data_prev", in_data, 32'h0000_00A5);
        confirm_btn = 1'b1;
        tick(); tick(); tick();
        reset = 1'b0;
        #1;
        check("rin_reg_write", 32'(reg_write), 32'd0);
        tick();
        check("rin_in_data", in_data, 32'd0);
        check("rin_pc", 32'(pc), 32'd0);
        check("rin_stall_after", 32'(stall), 32'd0);
        reset = 1'b1; idle(); confirm_btn = 1'b0;
        tick(); tick(); tick();

        // HALT absorption
        idle(); pc_signal = 1'b1; jump = 1'b1; target = 10'd3;
        tick();
        check("halt_setup_pc", 32'(pc), 32'd3);
        idle(); pc_signal = 1'b1; halt = 1'b1;
        tick();
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_stall", 32'(stall), 32'd1);
        for (int i = 0; i < 100; i++) begin
            halt = 1'b0; pc_signal = 1'b1; jump = 1'b1;
            target = AW'($urandom);
            confirm_btn = 1'($urandom_range(0, 1));
            tick();
            check("halt_pc", 32'(pc), 32'd3);
            check("halt_flag", 32'(halted), 32'd1);
        end
        idle(); confirm_btn = 1'b0;
        reset = 1'b0; tick(); reset = 1'b1;
        check("halt_reset_pc", 32'(pc), 32'd0);
        check("halt_reset_halted", 32'(halted), 32'd0);
        check("halt_reset_stall", 32'(stall), 32'd0);
        tick();
        check("halt_reset_run", 32'(pc), 32'd1);

        // Randomized run against the reference model
        reset = 1'b0; tick(); reset = 1'b1;
        model_reset();
        for (int k = 0; k < 3000; k++) begin
            reset = !($urandom_range(0, 79) == 0 || (m_mode == M_HALT && $urandom_range(0, 9) == 0));
            if ($urandom_range(0, 3) == 0) confirm_btn = ~confirm_btn;
            pc_signal   = 1'($urandom_range(0, 1));
            jump        = ($urandom_range(0, 3) == 0);
            branch      = ($urandom_range(0, 2) == 0);
            branch_cond = 1'($urandom_range(0, 1));
            is_in       = ($urandom_range(0, 11) == 0);
            is_out      = ($urandom_range(0, 11) == 0);
            halt        = ($urandom_range(0, 29) == 0);
            write       = 1'($urandom_range(0, 1));
            target      = AW'($urandom);
            reg_data    = $urandom;
            switches    = 16'($urandom);

            l          = hist.size();
            pulse_now  = hist[l-1-S] && !hist[l-2-S];
            commit_now = pulse_now && (m_cyc > m_entry);
            if (!reset)                exp_rw = 1'b0;
            else if (m_mode == M_RUN)  exp_rw = write && !is_in;
            else if (m_mode == M_IN)   exp_rw = commit_now;
            else                       exp_rw = 1'b0;
            #1;
            check("rand_reg_write", 32'(reg_write), 32'(exp_rw));

            if (!reset) begin
                model_reset();
            end else begin
                case (m_mode)
                    M_RUN: begin
                        if (is_in)                        begin m_mode = M_IN;  m_entry = m_cyc + 1; end
                        else if (is_out)                  begin m_mode = M_OUT; m_entry = m_cyc + 1; m_out = reg_data; end
                        else if (halt)                    m_mode = M_HALT;
                        else if (!pc_signal)              m_pc = m_pc + 1'b1;
                        else if (jump)                    m_pc = target;
                        else if (branch && branch_cond)   m_pc = target;
                        else                              m_pc = m_pc + 1'b1;
                    end
                    M_IN:  if (commit_now) begin m_in = {16'b0, switches}; m_pc = m_pc + 1'b1; m_mode = M_RUN; end
                    M_OUT: if (commit_now) begin m_pc = m_pc + 1'b1; m_mode = M_RUN; end
                    default: ;
                endcase
                hist.push_back(confirm_btn);
                if (hist.size() > 2 * S + 4) void'(hist.pop_front());
                m_cyc++;
            end

            tick();
            check("rand_pc", 32'(pc), 32'(m_pc));
            check("rand_stall", 32'(stall), 32'(m_mode != M_RUN));
            check("rand_halted", 32'(halted), 32'(m_mode == M_HALT));
            check("rand_in_data", in_data, m_in);
            check("rand_out_data", out_data, m_out);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
